seq_detect_prog: RTL

- Programmable serial pattern detector. Generalises the team's fixed-pattern Moore sequence detector to a runtime-loadable pattern of 1..PAT_W bits.
- Runtime modes: overlapping or non-overlapping detection, a bit-valid qualifier, and a saturating match counter.
- Sits behind the tile's dedicated inputs, with its state and count mapped to outputs for on-chip observation.
- All outputs are registered. No clock-gated outputs.

---
 rtl/seq_detect_prog.sv | 105 ++++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: runtime-loadable 1..PAT_W-bit pattern,
// overlapping/non-overlapping modes, and a saturating match counter.
module seq_detect_prog #(
    parameter int unsigned      PAT_W   = 8,
    parameter int unsigned      CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1101),
    parameter int unsigned      DEF_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         bit_valid,
    input  logic                         bit_in,
    input  logic                         overlap_en,
    input  logic                         load,
    input  logic [PAT_W-1:0]             pat_in,
    input  logic [$clog2(PAT_W+1)-1:0]   len_in,
    input  logic                         cnt_clr,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat,
    output logic [$clog2(PAT_W+1)-1:0]   fill
);

    localparam int unsigned LW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist, hist_nx;
    logic [PAT_W-1:0] pat_reg, pat_nx;
    logic [LW-1:0]    len_reg, len_nx, len_norm;
    logic [LW-1:0]    fill_nx;
    logic [PAT_W-1:0] mask;
    logic             match_nx;
    logic             inc;
    logic [CNT_W-1:0] cnt_nx;
    logic             sat_nx;

    always_comb begin
        len_norm = len_in;
        if (len_in == '0)
            len_norm = LW'(1);
        else if (32'(len_in) > PAT_W)
            len_norm = LW'(PAT_W);
    end

    // match is registered: decode the next state here so the counter and the
    // match flop see the same value on the accept edge.
    always_comb begin
        hist_nx = hist;
        fill_nx = fill;
        pat_nx  = pat_reg;
        len_nx  = len_reg;
        if (load) begin
            pat_nx  = pat_in;
            len_nx  = len_norm;
            hist_nx = '0;
            fill_nx = '0;
        end else if (bit_valid) begin
            hist_nx = {hist[PAT_W-2:0], bit_in};
            if (!overlap_en && match)
                fill_nx = LW'(1);
            else if (fill != len_reg)
                fill_nx = fill + LW'(1);
        end

        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++)
            mask[i] = (i < 32'(len_nx));
        match_nx = (fill_nx == len_nx) && (((hist_nx ^ pat_nx) & mask) == '0);
        inc      = !load && bit_valid && match_nx;
    end

    always_comb begin
        cnt_nx = match_cnt;
        sat_nx = cnt_sat;
        if (cnt_clr) begin
            cnt_nx = '0;
            sat_nx = 1'b0;
        end else begin
            if (inc && match_cnt != '1)
                cnt_nx = match_cnt + CNT_W'(1);
            if (cnt_nx == '1)
                sat_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist      <= '0;
            fill      <= '0;
            pat_reg   <= DEF_PAT;
            len_reg   <= LW'(DEF_LEN);
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            hist      <= hist_nx;
            fill      <= fill_nx;
            pat_reg   <= pat_nx;
            len_reg   <= len_nx;
            match     <= match_nx;
            match_cnt <= cnt_nx;
            cnt_sat   <= sat_nx;
        end
    end

endmodule
